// File: rtl/prod_burst_accumulator_pkg.sv
// Shared types and constants for the burst accumulator that sits behind the
// multiply-by-8 unit.
package prod_burst_accumulator_pkg;

  localparam int PROD_W = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Smallest accumulator width that cannot wrap for a burst of count products.
  function automatic int min_sum_w(input int count);
    return PROD_W + $clog2(count);
  endfunction

endpackage

// File: rtl/prod_burst_accumulator_if.sv
// Product input stream and held sum output stream of the burst accumulator.
// The accumulator takes the slave modport; its upstream/downstream neighbours take master.
interface prod_burst_accumulator_if
  import prod_burst_accumulator_pkg::*;
#(
  parameter int SUM_W = 10
);

  logic              in_valid;
  logic [PROD_W-1:0] in_data;
  logic              in_ready;
  logic [SUM_W-1:0]  sum;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  sum,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output sum,
    output out_valid
  );

endinterface

// File: rtl/prod_burst_accumulator.sv
// Sums COUNT products per burst, one per cycle; sum/out_valid appear the cycle after the last
// handshake and are held until out_ready; in_ready is low outside ACCUM, so input stalls there.
module prod_burst_accumulator
  import prod_burst_accumulator_pkg::*;
#(
  parameter int COUNT = 8,
  parameter int SUM_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  prod_burst_accumulator_if.slave  bus,
  output logic                     busy,
  output logic                     misalign
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             misalign_q, misalign_d;
  logic             busy_q, busy_d;
  logic             in_hs;
  logic [SUM_W-1:0] acc_inc;

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign busy          = busy_q;
  assign misalign      = misalign_q;

  assign in_hs   = bus.in_valid && (state_q == S_ACCUM);
  assign acc_inc = acc_q + SUM_W'(bus.in_data);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    misalign_d = misalign_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCUM;
          acc_d      = '0;
          cnt_d      = '0;
          misalign_d = 1'b0;
        end
      end

      S_ACCUM: begin
        if (in_hs) begin
          acc_d = acc_inc;
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.in_data[2:0] != 3'b000) begin
            misalign_d = 1'b1;
          end
          // The last product goes straight into the published sum.
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            sum_d   = acc_inc;
          end
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          if (start) begin
            state_d    = S_ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            misalign_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      misalign_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      misalign_q <= misalign_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_prod_burst_accumulator.sv
// Randomized and directed stimulus for prod_burst_accumulator, compared every cycle
// against a burst-level reference model.
module tb_prod_burst_accumulator;
  import prod_burst_accumulator_pkg::*;

  localparam int COUNT = 8;
  localparam int SUM_W = min_sum_w(COUNT);

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic misalign;

  int n_total;
  int n_bad;

  // Reference model: burst phase, products taken, running total, sticky flag, published sum.
  int m_phase;
  int m_taken;
  int m_total;
  bit m_mis;
  int m_sum;

  prod_burst_accumulator_if #(.SUM_W(SUM_W)) bus_if ();

  prod_burst_accumulator #(
    .COUNT (COUNT),
    .SUM_W (SUM_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus_if.slave),
    .busy     (busy),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_taken = 0;
    m_total = 0;
    m_mis   = 1'b0;
    m_sum   = 0;
  endtask

  task automatic model_begin_burst();
    m_phase = 1;
    m_taken = 0;
    m_total = 0;
    m_mis   = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit iv, input logic [6:0] d, input bit ordy);
    if (m_phase == 0) begin
      if (s) model_begin_burst();
    end else if (m_phase == 1) begin
      if (iv) begin
        m_total += int'(d);
        if (d % 8 != 0) m_mis = 1'b1;
        m_taken++;
        if (m_taken == COUNT) begin
          m_phase = 2;
          m_sum   = m_total % (1 << SUM_W);
        end
      end
    end else begin
      if (ordy) begin
        if (s) model_begin_burst();
        else   m_phase = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready",  32'(bus_if.in_ready),  32'(m_phase == 1));
    chk("out_valid", 32'(bus_if.out_valid), 32'(m_phase == 2));
    chk("busy",      32'(busy),             32'(m_phase != 0));
    chk("misalign",  32'(misalign),         32'(m_mis));
    chk("sum",       32'(bus_if.sum),       32'(m_sum));
  endtask

  task automatic cycle(input bit s, input bit iv, input logic [6:0] d, input bit ordy);
    start            = s;
    bus_if.in_valid  = iv;
    bus_if.in_data   = d;
    bus_if.out_ready = ordy;
    @(posedge clk);
    model_step(s, iv, d, ordy);
    #1;
    check_all();
  endtask

  initial begin
    logic [6:0] d;
    bit         s, iv, ordy;

    n_total = 0;
    n_bad   = 0;
    model_reset();
    rst_n            = 1'b0;
    start            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 7'd0, 0);

    // Sequential burst 8,16,...,64 with the consumer not yet ready.
    cycle(1, 0, 7'd0, 0);
    for (int i = 1; i <= COUNT; i++) cycle(0, 1, 7'(i * 8), 0);
    chk("seq_vld", 32'(bus_if.out_valid), 32'd1);
    chk("seq_sum", 32'(bus_if.sum), 32'd288);
    chk("seq_mis", 32'(misalign), 32'd0);
    cycle(0, 0, 7'd0, 1);

    // Maximum products, then 5 cycles of output backpressure with input offered.
    cycle(1, 0, 7'd0, 0);
    for (int i = 0; i < COUNT; i++) cycle(0, 1, 7'd120, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 7'd8, 0);
    chk("bp_sum", 32'(bus_if.sum), 32'd960);
    chk("bp_rdy", 32'(bus_if.in_ready), 32'd0);
    cycle(0, 0, 7'd0, 1);

    // Input gaps every other cycle; a stray start mid-burst is ignored.
    cycle(1, 0, 7'd0, 0);
    for (int i = 0; i < 2 * COUNT; i++) cycle(i == 5, (i % 2) == 0, 7'd8, 0);
    chk("gap_sum", 32'(bus_if.sum), 32'd64);
    cycle(0, 0, 7'd0, 1);

    // One misaligned product, then a clean burst clears the flag.
    cycle(1, 0, 7'd0, 0);
    for (int i = 0; i < COUNT; i++) cycle(0, 1, (i == 3) ? 7'd5 : 7'd8, 0);
    chk("mis_set", 32'(misalign), 32'd1);
    chk("mis_sum", 32'(bus_if.sum), 32'd61);
    cycle(0, 0, 7'd0, 1);
    cycle(1, 0, 7'd0, 0);
    for (int i = 0; i < COUNT; i++) cycle(0, 1, 7'd24, 0);
    chk("mis_clr", 32'(misalign), 32'd0);
    cycle(0, 0, 7'd0, 1);

    // Asynchronous reset after three handshakes discards the partial burst.
    cycle(1, 0, 7'd0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 7'd16, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 7'd0, 0);
    for (int i = 0; i < COUNT; i++) cycle(0, 1, 7'd16, 0);
    chk("post_rst_sum", 32'(bus_if.sum), 32'd128);

    // Back-to-back burst: start with out_ready in DONE.
    cycle(1, 0, 7'd0, 1);
    chk("b2b_rdy", 32'(bus_if.in_ready), 32'd1);
    for (int i = 0; i < COUNT; i++) cycle(0, 1, 7'd112, 0);
    chk("b2b_sum", 32'(bus_if.sum), 32'd896);
    cycle(0, 0, 7'd0, 1);

    // Random traffic, including unaligned and out-of-range products.
    for (int i = 0; i < 3000; i++) begin
      s    = ($urandom_range(0, 4) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) d = 7'($urandom_range(0, 127));
      else                          d = 7'($urandom_range(0, 15) * 8);
      cycle(s, iv, d, ordy);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
